// File: rtl/ps2_host_cmd.sv
// ps2_host_cmd: PS/2 host-to-device command controller.
// Queues command bytes, inhibits the bus, shifts each byte out on the device
// clock with odd parity, checks the line ACK and waits for the device reply
// (0xFA accept / 0xFE resend) from the shared receive path.
// Optional feature macro: PS2_RESEND_EN (resend the byte on 0xFE, up to MAX_RETRY
// resends). Without it a 0xFE reply aborts the command at once.
// INHIBIT_CYCLES must be smaller than TIMEOUT_CYCLES; FIFO_DEPTH is a power of two >= 2.
module ps2_host_cmd #(
  parameter int INHIBIT_CYCLES = 600,
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int FIFO_DEPTH     = 4
`ifdef PS2_RESEND_EN
  ,
  parameter int MAX_RETRY      = 3
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       busy,
  output logic       err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_RESEND_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACKBIT, S_RESP, S_ABORT
  } state_t;

  // Odd parity bit for a PS/2 frame: 1 when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t          state_r;
  logic [7:0]      fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [7:0]      filt_sh_r;
  logic            filt_lvl_r;
  logic [TW-1:0]   tick_r;
  logic [3:0]      bit_r;
  logic [9:0]      frame_r;
  logic            err_r, c_oe_r, d_oe_r;
`ifdef PS2_RESEND_EN
  logic [RW-1:0]   retry_r;
`endif

  logic            push_s, pop_s, fall_s, timeout_s;
  logic [7:0]      filt_next_s, head_s;

  assign cmd_ready   = (count_r != CW'(FIFO_DEPTH));
  assign busy        = (state_r != S_IDLE) || (count_r != {CW{1'b0}});
  assign err         = err_r;
  assign ps2c_oe     = c_oe_r;
  assign ps2d_oe     = d_oe_r;
  assign push_s      = ce & cmd_valid & cmd_ready;
  assign head_s      = fifo_mem_r[rd_ptr_r];
  assign filt_next_s = {filt_sh_r[6:0], ps2c_i};
  // A falling edge is the filtered level dropping from high to all-low samples;
  // our own clock inhibit never counts as a device edge.
  assign fall_s      = ce & ~c_oe_r & filt_lvl_r & (filt_next_s == 8'h00);
  assign timeout_s   = (state_r != S_IDLE) && (state_r != S_ABORT) &&
                       (tick_r == TW'(TIMEOUT_CYCLES - 1));

  // Head byte leaves the queue on an accepted reply or on any abort.
  always_comb begin
    pop_s = 1'b0;
    if (ce && state_r == S_ABORT) begin
      pop_s = 1'b1;
    end else if (ce && !timeout_s && state_r == S_RESP && rx_valid && rx_data == 8'hFA) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Glitch filter on the sampled PS/2 clock; held released while we inhibit the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_sh_r  <= 8'hFF;
      filt_lvl_r <= 1'b1;
    end else if (ce) begin
      if (c_oe_r) begin
        filt_sh_r  <= 8'hFF;
        filt_lvl_r <= 1'b1;
      end else begin
        filt_sh_r <= filt_next_s;
        if (&filt_next_s)       filt_lvl_r <= 1'b1;
        else if (~|filt_next_s) filt_lvl_r <= 1'b0;
      end
    end
  end

  // Queue storage; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= cmd_data;
  end

  // Queue pointers and occupancy; push and pop in one tick both take effect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Command FSM: inhibit, request-to-send, shift out, ACK check, reply wait.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      c_oe_r  <= 1'b0;
      d_oe_r  <= 1'b0;
      err_r   <= 1'b0;
      tick_r  <= {TW{1'b0}};
      bit_r   <= 4'd0;
      frame_r <= 10'd0;
`ifdef PS2_RESEND_EN
      retry_r <= {RW{1'b0}};
`endif
    end else if (ce) begin
      if (push_s) err_r <= 1'b0;
      if (timeout_s) begin
        state_r <= S_ABORT;
        tick_r  <= {TW{1'b0}};
      end else begin
        case (state_r)
          S_IDLE: begin
            tick_r <= {TW{1'b0}};
            if (count_r != {CW{1'b0}}) begin
              frame_r <= {1'b1, odd_parity(head_s), head_s};
              c_oe_r  <= 1'b1;
              d_oe_r  <= 1'b0;
              state_r <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (tick_r == TW'(INHIBIT_CYCLES - 1)) begin
              tick_r  <= {TW{1'b0}};
              state_r <= S_RTS;
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end
          S_RTS: begin
            // Start bit: data low and clock released on the same tick.
            d_oe_r  <= 1'b1;
            c_oe_r  <= 1'b0;
            bit_r   <= 4'd0;
            tick_r  <= {TW{1'b0}};
            state_r <= S_SHIFT;
          end
          S_SHIFT: begin
            if (fall_s) begin
              tick_r <= {TW{1'b0}};
              d_oe_r <= ~frame_r[bit_r];
              if (bit_r == 4'd9) state_r <= S_ACKBIT;
              else               bit_r   <= bit_r + 4'd1;
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end
          S_ACKBIT: begin
            if (fall_s) begin
              tick_r  <= {TW{1'b0}};
              state_r <= ps2d_i ? S_ABORT : S_RESP;
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end
          S_RESP: begin
            if (rx_valid && rx_data == 8'hFA) begin
              tick_r  <= {TW{1'b0}};
              state_r <= S_IDLE;
`ifdef PS2_RESEND_EN
              retry_r <= {RW{1'b0}};
`endif
            end else if (rx_valid && rx_data == 8'hFE) begin
              tick_r <= {TW{1'b0}};
`ifdef PS2_RESEND_EN
              // The count records resends already made; the first 0xFE
              // beyond the limit gives up.
              if (retry_r < RW'(MAX_RETRY)) begin
                retry_r <= retry_r + RW'(1);
                c_oe_r  <= 1'b1;
                d_oe_r  <= 1'b0;
                state_r <= S_INHIBIT;
              end else begin
                state_r <= S_ABORT;
              end
`else
              state_r <= S_ABORT;
`endif
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end
          S_ABORT: begin
            c_oe_r  <= 1'b0;
            d_oe_r  <= 1'b0;
            err_r   <= 1'b1;
            tick_r  <= {TW{1'b0}};
            state_r <= S_IDLE;
`ifdef PS2_RESEND_EN
            retry_r <= {RW{1'b0}};
`endif
          end
          default: begin
            c_oe_r  <= 1'b0;
            d_oe_r  <= 1'b0;
            tick_r  <= {TW{1'b0}};
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_cmd.sv
// tb_ps2_host_cmd: self-checking bench for ps2_host_cmd with a small PS/2 device
// model that clocks frames on the wired-AND bus and samples the host data line.
module tb_ps2_host_cmd;

  localparam int INH  = 30;
  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset, ce;
  logic       ps2c_oe, ps2d_oe, cmd_ready, busy, err;
  logic       cmd_valid, rx_valid;
  logic [7:0] cmd_data, rx_data;
  logic       dev_c_low, dev_d_low;
  logic       ps2c_line, ps2d_line;

  int checks = 0;
  int errors = 0;

  assign ps2c_line = ~(ps2c_oe | dev_c_low);
  assign ps2d_line = ~(ps2d_oe | dev_d_low);

  ps2_host_cmd #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .ce(ce),
    .ps2c_i(ps2c_line), .ps2d_i(ps2d_line),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // Global guard so the run always ends.
  initial begin
    #(600000);
    $display("FAIL watchdog: got no_finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic reply(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Device model: waits for inhibit and RTS, then gives npulses clocks.
  // bits[0] = start bit seen before the first clock, bits[i] sampled after pulse i.
  task automatic dev_frame(input int npulses, input bit ack,
                           output logic [10:0] bits, output int inh);
    int n;
    bits = 11'd0;
    inh  = 0;
    n = 0;
    while (!ps2c_oe && n < 3000) begin tick(); n++; end
    if (!ps2c_oe) begin chk("dev_wait_inhibit", 0, 1); return; end
    n = 0;
    while (ps2c_oe && n < 3000) begin inh++; tick(); n++; end
    if (ps2c_oe) begin chk("dev_wait_release", 1, 0); return; end
    repeat (5) tick();
    bits[0] = ps2d_line;
    for (int i = 1; i <= npulses; i++) begin
      repeat (HALF) tick();
      if (i == 11 && ack) dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      repeat (HALF) tick();
      dev_c_low = 1'b0;
      if (i <= 10) bits[i] = ps2d_line;
    end
    repeat (2) tick();
    dev_d_low = 1'b0;
  endtask

  typedef struct {
    logic       ce, v;
    logic [7:0] d;
    logic       rxv;
    logic [7:0] rxd;
    logic       ready, busy, err, coe, doe;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [10:0] bits;
    int inh, n, hi;

    // ce, valid, data, rx_valid, rx_data -> ready, busy, err, ps2c_oe, ps2d_oe
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hED, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'hED, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h03, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; ce = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; dev_c_low = 1'b0; dev_d_low = 1'b0;
    repeat (3) tick();
    chk("rst_c_oe", ps2c_oe, 0);
    chk("rst_d_oe", ps2d_oe, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    // Queue fill with a silent device: four accepted, fifth dropped.
    for (int i = 0; i < 9; i++) begin
      ce = vecs[i].ce; cmd_valid = vecs[i].v; cmd_data = vecs[i].d;
      rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd;
      tick();
      chk($sformatf("vec%0d_ready", i), cmd_ready, vecs[i].ready);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
      chk($sformatf("vec%0d_c_oe", i), ps2c_oe, vecs[i].coe);
      chk($sformatf("vec%0d_d_oe", i), ps2d_oe, vecs[i].doe);
    end
    ce = 1'b1; cmd_valid = 1'b0; rx_valid = 1'b0;

    // First byte: no device clocks after RTS, so it must time out.
    n = 0;
    while (ps2c_oe && n < 200) begin tick(); n++; end
    chk("rts_reached", ps2c_oe, 0);
    n = 0;
    while (!err && n < 1000) begin tick(); n++; end
    chk("timeout_err", err, 1);
    chk("timeout_len", (n >= TMO && n <= TMO + 2) ? 1 : 0, 1);
    chk("timeout_c_rel", ps2c_oe, 0);
    chk("timeout_d_rel", ps2d_oe, 0);
    chk("timeout_popped", cmd_ready, 1);
    // Remaining three queued bytes each start (and time out); the fifth never existed.
    hi = 0;
    n = 0;
    while (busy && n < 5000) begin
      logic prev;
      prev = ps2c_oe;
      tick();
      if (ps2c_oe && !prev) hi++;
      n++;
    end
    chk("drain_idle", busy, 0);
    chk("drain_frames", hi, 3);

    // Single 0xED command with ACK and 0xFA reply; push clears sticky err.
    push(8'hED);
    chk("push_clears_err", err, 0);
    dev_frame(11, 1'b1, bits, inh);
    // Odd parity for 0xED (six ones) is 1.
    chk("frame_ed", bits, {1'b1, 1'b1, 8'hED, 1'b0});
    reply(8'hFA);
    tick();
    chk("ed_busy", busy, 0);
    chk("ed_err", err, 0);

    // Back-to-back 0xED, 0x02.
    push(8'hED);
    push(8'h02);
    dev_frame(11, 1'b1, bits, inh);
    chk("b2b_frame1", bits, {1'b1, 1'b1, 8'hED, 1'b0});
    chk("b2b_inh1", (inh >= INH) ? 1 : 0, 1);
    reply(8'hFA);
    dev_frame(11, 1'b1, bits, inh);
    chk("b2b_frame2", bits, {1'b1, 1'b0, 8'h02, 1'b0});
    chk("b2b_inh2", (inh >= INH) ? 1 : 0, 1);
    reply(8'hFA);
    tick();
    chk("b2b_busy", busy, 0);
    chk("b2b_err", err, 0);

    // Missing ACK aborts the first byte; the next queued byte still goes out.
    push(8'h11);
    push(8'h22);
    dev_frame(11, 1'b0, bits, inh);
    chk("noack_frame", bits, {1'b1, 1'b1, 8'h11, 1'b0});
    chk("noack_err", err, 1);
    dev_frame(11, 1'b1, bits, inh);
    chk("after_noack_frame", bits, {1'b1, 1'b1, 8'h22, 1'b0});
    reply(8'hFA);
    tick();
    chk("after_noack_busy", busy, 0);
    chk("after_noack_err_sticky", err, 1);

    // 0xFE replies: resend up to three times, or abort when resend is off.
    push(8'hF4);
    chk("retry_push_clr", err, 0);
`ifdef PS2_RESEND_EN
    for (int r = 0; r < 4; r++) begin
      dev_frame(11, 1'b1, bits, inh);
      chk($sformatf("resend_frame%0d", r), bits, {1'b1, 1'b0, 8'hF4, 1'b0});
      reply((r < 3) ? 8'hFE : 8'hFA);
    end
    tick();
    chk("resend_err", err, 0);
    chk("resend_busy", busy, 0);
`else
    dev_frame(11, 1'b1, bits, inh);
    chk("fe_frame", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
    reply(8'hFE);
    repeat (2) tick();
    chk("fe_err", err, 1);
    chk("fe_busy", busy, 0);
    hi = 0;
    for (int k = 0; k < 100; k++) begin tick(); if (ps2c_oe) hi++; end
    chk("fe_no_resend", hi, 0);
`endif

    // Asynchronous reset in the middle of the frame (after d4 is driven).
    push(8'h45);
    push(8'h46);
    dev_frame(5, 1'b1, bits, inh);
    chk("mid_d_oe_before", ps2d_oe, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_c_oe", ps2c_oe, 0);
    chk("mid_rst_d_oe", ps2d_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    tick();
    reset = 1'b0;
    repeat (INH + 5) tick();
    chk("post_rst_idle_c", ps2c_oe, 0);
    chk("post_rst_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
